// File: rtl/edge_cache_arbiter_pkg.sv
// Shared types and width defaults for the EdgeCache arbiter.
package edge_cache_arbiter_pkg;

  localparam int unsigned DefaultNodeWidth  = 16;
  localparam int unsigned DefaultValueWidth = 32;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbGrant,
    ArbRelease
  } arb_state_t;

  typedef enum logic {
    ReqHost,
    ReqEng
  } arb_owner_t;

endpackage

// File: rtl/edge_cache_arbiter.sv
// Arbitrates the single EdgeCache port between the host (read/write) and the
// engine (read only). The engine has fixed priority; after STARVE_LIMIT engine
// grants with the host waiting, the host is forced through. The granted command
// is latched and held on the cache port until ec_ready_i or a timeout, read data
// is registered per requester, and a one-cycle done (plus error on timeout) pulse
// is returned to the owner. A one-cycle release gap with enables low follows
// every access.
// Ports:
//   clock_i, reset_i          clock, synchronous active-high reset
//   host_*_i / host_*_o       host request, command, done pulse, read data
//   eng_*_i / eng_*_o         engine request, address, done pulse, read data
//   error_o                   timeout flag, pulses together with done
//   ec_*_o / ec_*_i           EdgeCache command port and response
module edge_cache_arbiter
  import edge_cache_arbiter_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH  = DefaultValueWidth,
  parameter int unsigned NODE_WIDTH   = DefaultNodeWidth,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   host_req_i,
  input  logic                   host_we_i,
  input  logic [NODE_WIDTH-1:0]  host_from_i,
  input  logic [NODE_WIDTH-1:0]  host_to_i,
  input  logic [VALUE_WIDTH-1:0] host_wdata_i,
  output logic                   host_done_o,
  output logic [VALUE_WIDTH-1:0] host_rdata_o,
  input  logic                   eng_req_i,
  input  logic [NODE_WIDTH-1:0]  eng_from_i,
  input  logic [NODE_WIDTH-1:0]  eng_to_i,
  output logic                   eng_done_o,
  output logic [VALUE_WIDTH-1:0] eng_rdata_o,
  output logic                   error_o,
  output logic                   ec_reset_o,
  output logic                   ec_read_o,
  output logic                   ec_write_o,
  output logic [NODE_WIDTH-1:0]  ec_from_o,
  output logic [NODE_WIDTH-1:0]  ec_to_o,
  output logic [VALUE_WIDTH-1:0] ec_wdata_o,
  input  logic                   ec_ready_i,
  input  logic [VALUE_WIDTH-1:0] ec_rdata_i
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TimerMax  = TW'(TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  arb_owner_t             owner_q, owner_d;
  logic                   we_q, we_d;
  logic [NODE_WIDTH-1:0]  from_q, from_d, to_q, to_d;
  logic [VALUE_WIDTH-1:0] wdata_q, wdata_d;
  logic [VALUE_WIDTH-1:0] host_rdata_q, host_rdata_d, eng_rdata_q, eng_rdata_d;
  logic                   host_done_q, host_done_d, eng_done_q, eng_done_d;
  logic                   error_q, error_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   host_forced;

  assign host_forced = host_req_i && (starve_q == StarveMax);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    from_d       = from_q;
    to_d         = to_q;
    wdata_d      = wdata_q;
    host_rdata_d = host_rdata_q;
    eng_rdata_d  = eng_rdata_q;
    host_done_d  = 1'b0;
    eng_done_d   = 1'b0;
    error_d      = 1'b0;
    starve_d     = starve_q;
    timer_d      = timer_q;

    unique case (state_q)
      ArbIdle: begin
        timer_d = '0;
        if (eng_req_i && !host_forced) begin
          state_d = ArbGrant;
          owner_d = ReqEng;
          we_d    = 1'b0;
          from_d  = eng_from_i;
          to_d    = eng_to_i;
          // Count engine wins only while the host is actually waiting.
          if (!host_req_i) begin
            starve_d = '0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (host_req_i) begin
          state_d  = ArbGrant;
          owner_d  = ReqHost;
          we_d     = host_we_i;
          from_d   = host_from_i;
          to_d     = host_to_i;
          wdata_d  = host_wdata_i;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      ArbGrant: begin
        if (ec_ready_i || (timer_q == TimerMax)) begin
          state_d = ArbRelease;
          timer_d = '0;
          error_d = !ec_ready_i;
          if (owner_q == ReqEng) begin
            eng_done_d = 1'b1;
            if (!ec_ready_i) begin
              eng_rdata_d = '0;
            end else if (!we_q) begin
              eng_rdata_d = ec_rdata_i;
            end
          end else begin
            host_done_d = 1'b1;
            if (!ec_ready_i) begin
              host_rdata_d = '0;
            end else if (!we_q) begin
              host_rdata_d = ec_rdata_i;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ArbRelease: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ArbIdle;
      owner_q      <= ReqHost;
      we_q         <= 1'b0;
      from_q       <= '0;
      to_q         <= '0;
      wdata_q      <= '0;
      host_rdata_q <= '0;
      eng_rdata_q  <= '0;
      host_done_q  <= 1'b0;
      eng_done_q   <= 1'b0;
      error_q      <= 1'b0;
      starve_q     <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      from_q       <= from_d;
      to_q         <= to_d;
      wdata_q      <= wdata_d;
      host_rdata_q <= host_rdata_d;
      eng_rdata_q  <= eng_rdata_d;
      host_done_q  <= host_done_d;
      eng_done_q   <= eng_done_d;
      error_q      <= error_d;
      starve_q     <= starve_d;
      timer_q      <= timer_d;
    end
  end

  assign ec_reset_o   = reset_i;
  assign ec_read_o    = (state_q == ArbGrant) && !we_q;
  assign ec_write_o   = (state_q == ArbGrant) && we_q;
  assign ec_from_o    = from_q;
  assign ec_to_o      = to_q;
  assign ec_wdata_o   = wdata_q;
  assign host_done_o  = host_done_q;
  assign host_rdata_o = host_rdata_q;
  assign eng_done_o   = eng_done_q;
  assign eng_rdata_o  = eng_rdata_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_edge_cache_arbiter.sv
module tb_edge_cache_arbiter;

  localparam int unsigned NW    = 16;
  localparam int unsigned VW    = 32;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned TMO   = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, host_req, host_we, host_done, eng_req, eng_done, error;
  logic [NW-1:0] host_from, host_to, eng_from, eng_to, ec_from, ec_to;
  logic [VW-1:0] host_wdata, host_rdata, eng_rdata, ec_wdata, ec_rdata;
  logic          ec_reset, ec_read, ec_write, ec_ready;

  edge_cache_arbiter #(
    .VALUE_WIDTH (VW),
    .NODE_WIDTH  (NW),
    .STARVE_LIMIT(LIMIT),
    .TIMEOUT     (TMO)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .host_req_i  (host_req),
    .host_we_i   (host_we),
    .host_from_i (host_from),
    .host_to_i   (host_to),
    .host_wdata_i(host_wdata),
    .host_done_o (host_done),
    .host_rdata_o(host_rdata),
    .eng_req_i   (eng_req),
    .eng_from_i  (eng_from),
    .eng_to_i    (eng_to),
    .eng_done_o  (eng_done),
    .eng_rdata_o (eng_rdata),
    .error_o     (error),
    .ec_reset_o  (ec_reset),
    .ec_read_o   (ec_read),
    .ec_write_o  (ec_write),
    .ec_from_o   (ec_from),
    .ec_to_o     (ec_to),
    .ec_wdata_o  (ec_wdata),
    .ec_ready_i  (ec_ready),
    .ec_rdata_i  (ec_rdata)
  );

  typedef struct packed {
    logic          is_eng;
    logic [VW-1:0] rdata;
    logic          err;
  } done_t;

  typedef struct packed {
    logic          we;
    logic [NW-1:0] from;
    logic [NW-1:0] to;
    logic [VW-1:0] wdata;
  } cmd_t;

  done_t exp_done_q[$];
  cmd_t  exp_cmd_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  logic [VW-1:0] cache_mem[logic [31:0]];
  logic [VW-1:0] ref_mem[logic [31:0]];
  int            ref_starve = 0;
  logic [VW-1:0] ref_host_rdata = '0;
  logic [VW-1:0] ref_eng_rdata = '0;
  logic [NW-1:0] eng_from_a[8];
  logic [NW-1:0] eng_to_a[8];
  int            force_lat = -1;
  int            last_len = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endfunction

  // Unwritten edges hold a deterministic pseudo-random weight.
  function automatic logic [VW-1:0] init_val(logic [31:0] key);
    return (key * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [VW-1:0] cache_rd(logic [31:0] key);
    return cache_mem.exists(key) ? cache_mem[key] : init_val(key);
  endfunction

  function automatic logic [VW-1:0] ref_rd(logic [31:0] key);
    return ref_mem.exists(key) ? ref_mem[key] : init_val(key);
  endfunction

  // Reference model: what one host access must produce.
  function automatic void exp_host(logic we, logic [NW-1:0] f, logic [NW-1:0] t,
                                   logic [VW-1:0] wd);
    exp_cmd_q.push_back('{we: we, from: f, to: t, wdata: wd});
    if (we) ref_mem[{f, t}] = wd;
    else ref_host_rdata = ref_rd({f, t});
    exp_done_q.push_back('{is_eng: 1'b0, rdata: ref_host_rdata, err: 1'b0});
    ref_starve = 0;
  endfunction

  function automatic void exp_eng(logic [NW-1:0] f, logic [NW-1:0] t, bit host_waiting);
    exp_cmd_q.push_back('{we: 1'b0, from: f, to: t, wdata: '0});
    ref_eng_rdata = ref_rd({f, t});
    exp_done_q.push_back('{is_eng: 1'b1, rdata: ref_eng_rdata, err: 1'b0});
    if (!host_waiting) ref_starve = 0;
    else if (ref_starve < int'(LIMIT)) ref_starve++;
  endfunction

  // Host and a k-long engine burst request together: engine wins until the host
  // has watched LIMIT engine grants go by.
  function automatic void plan_both(int k, logic hwe, logic [NW-1:0] hf, logic [NW-1:0] ht,
                                    logic [VW-1:0] hwd);
    int e = 0;
    bit hp = 1'b1;
    while (e < k || hp) begin
      if (e < k && !(hp && ref_starve == int'(LIMIT))) begin
        exp_eng(eng_from_a[e], eng_to_a[e], hp);
        e++;
      end else begin
        exp_host(hwe, hf, ht, hwd);
        hp = 1'b0;
      end
    end
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_done(bit eng, output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      cycles++;
      if (eng ? eng_done : host_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(eng ? "eng_done_wait" : "host_done_wait", ok, 1);
  endtask

  task automatic host_access(logic we, logic [NW-1:0] f, logic [NW-1:0] t,
                             logic [VW-1:0] wd);
    int cyc;
    host_req   = 1'b1;
    host_we    = we;
    host_from  = f;
    host_to    = t;
    host_wdata = wd;
    wait_done(1'b0, cyc);
    host_req   = 1'b0;
    host_we    = 1'($urandom);
    host_from  = NW'($urandom);
    host_wdata = $urandom;
  endtask

  task automatic eng_burst(int k, output int first_cyc);
    int cyc;
    first_cyc = 0;
    eng_req = 1'b1;
    for (int i = 0; i < k; i++) begin
      eng_from = eng_from_a[i];
      eng_to   = eng_to_a[i];
      wait_done(1'b1, cyc);
      if (i == 0) first_cyc = cyc;
    end
    eng_req  = 1'b0;
    eng_from = NW'($urandom);
  endtask

  // Cache model: checks the command it sees and answers after a chosen latency.
  initial begin
    bit   active = 1'b0;
    bit   gap = 1'b0;
    int   cnt = 0, lat = 0, len = 0;
    cmd_t cmd = '0;
    forever begin
      @(posedge clock);
      #1;
      if (gap) begin
        chk("release_gap_enables_low", {ec_read, ec_write}, 2'b00);
        gap = 1'b0;
      end
      ec_ready = 1'b0;
      ec_rdata = $urandom;
      if (ec_read || ec_write) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          len = 0;
          lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
          chk("single_enable", ec_read & ec_write, 1'b0);
          chk("cmd_expected", exp_cmd_q.size() != 0, 1'b1);
          if (exp_cmd_q.size() != 0) begin
            cmd = exp_cmd_q.pop_front();
            chk("cmd_write", ec_write, cmd.we);
            chk("cmd_from", ec_from, cmd.from);
            chk("cmd_to", ec_to, cmd.to);
            if (cmd.we) chk("cmd_wdata", ec_wdata, cmd.wdata);
          end
        end else begin
          chk("cmd_stable", {ec_write, ec_from, ec_to}, {cmd.we, cmd.from, cmd.to});
        end
        len++;
        if (cnt == lat) begin
          ec_ready = 1'b1;
          if (ec_write) cache_mem[{ec_from, ec_to}] = ec_wdata;
          else ec_rdata = cache_rd({ec_from, ec_to});
          gap = 1'b1;
        end
        cnt++;
      end else if (active) begin
        active = 1'b0;
        last_len = len;
      end
    end
  end

  // Done monitor: every done pulse must match the head of the expected queue.
  initial begin
    done_t d;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        if (host_done && eng_done) chk("done_exclusive", {host_done, eng_done}, 2'b10);
        if (host_done || eng_done) begin
          chk("done_expected", exp_done_q.size() != 0, 1'b1);
          if (exp_done_q.size() != 0) begin
            d = exp_done_q.pop_front();
            chk("done_owner", eng_done, d.is_eng);
            chk("done_rdata", d.is_eng ? eng_rdata : host_rdata, d.rdata);
            chk("done_error", error, d.err);
          end
        end else if (error) begin
          chk("error_without_done", error, 1'b0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic hwe;
    logic [NW-1:0] hf, ht;
    logic [VW-1:0] hwd;
    int k;

    reset = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_from = '0; host_to = '0; host_wdata = '0;
    eng_req = 1'b0; eng_from = '0; eng_to = '0;
    ec_ready = 1'b0; ec_rdata = '0;
    idle(3);
    chk("reset_ec_reset", ec_reset, 1'b1);
    chk("reset_enables", {ec_read, ec_write}, 2'b00);
    chk("reset_dones", {host_done, eng_done, error}, 3'b000);
    chk("reset_host_rdata", host_rdata, 0);
    chk("reset_eng_rdata", eng_rdata, 0);
    reset = 1'b0;
    idle(1);
    chk("ec_reset_released", ec_reset, 1'b0);

    // Host write 3->7, cache ready on the third grant cycle.
    force_lat = 2;
    exp_host(1'b1, 16'd3, 16'd7, 32'h3F80_0000);
    host_access(1'b1, 16'd3, 16'd7, 32'h3F80_0000);
    idle(1);

    // Engine read 1->2 with ready on the first grant cycle.
    cache_mem[{16'd1, 16'd2}] = 32'h4000_0000;
    ref_mem[{16'd1, 16'd2}]   = 32'h4000_0000;
    force_lat = 0;
    eng_from_a[0] = 16'd1;
    eng_to_a[0]   = 16'd2;
    exp_eng(16'd1, 16'd2, 1'b0);
    eng_burst(1, cyc);
    chk("eng_min_latency", cyc, 2);
    idle(1);

    // Both request together; engine keeps requesting six reads.
    force_lat = -1;
    for (int i = 0; i < 6; i++) begin
      eng_from_a[i] = NW'(10 + i);
      eng_to_a[i]   = NW'(20 + i);
    end
    plan_both(6, 1'b0, 16'd3, 16'd7, '0);
    fork
      host_access(1'b0, 16'd3, 16'd7, '0);
      eng_burst(6, cyc);
    join
    idle(1);

    // Cache never answers: timeout after TMO grant cycles.
    force_lat = 100000;
    eng_from_a[0] = 16'd5;
    eng_to_a[0]   = 16'd6;
    exp_cmd_q.push_back('{we: 1'b0, from: 16'd5, to: 16'd6, wdata: '0});
    ref_eng_rdata = '0;
    exp_done_q.push_back('{is_eng: 1'b1, rdata: '0, err: 1'b1});
    ref_starve = 0;
    eng_burst(1, cyc);
    idle(1);
    chk("timeout_grant_cycles", last_len, TMO);

    // Reset in the middle of a grant.
    exp_cmd_q.push_back('{we: 1'b0, from: 16'd8, to: 16'd9, wdata: '0});
    eng_req = 1'b1; eng_from = 16'd8; eng_to = 16'd9;
    idle(3);
    chk("pre_reset_ec_read", ec_read, 1'b1);
    reset = 1'b1;
    eng_req = 1'b0;
    idle(1);
    chk("reset_midgrant_ec_read", ec_read, 1'b0);
    chk("reset_midgrant_no_done", {eng_done, host_done, error}, 3'b000);
    chk("reset_midgrant_eng_rdata", eng_rdata, 0);
    reset = 1'b0;
    ref_eng_rdata = '0;
    ref_host_rdata = '0;
    ref_starve = 0;
    force_lat = -1;
    idle(1);
    eng_from_a[0] = 16'd1;
    eng_to_a[0]   = 16'd2;
    exp_eng(16'd1, 16'd2, 1'b0);
    eng_burst(1, cyc);

    // Randomized mix over a small address space so writes and reads collide.
    for (int it = 0; it < 40; it++) begin
      idle(int'($urandom_range(0, 2)));
      hwe = 1'($urandom);
      hf  = NW'($urandom_range(0, 3));
      ht  = NW'($urandom_range(0, 3));
      hwd = $urandom;
      k   = int'($urandom_range(1, 7));
      for (int i = 0; i < k; i++) begin
        eng_from_a[i] = NW'($urandom_range(0, 3));
        eng_to_a[i]   = NW'($urandom_range(0, 3));
      end
      case ($urandom_range(0, 2))
        0: begin
          exp_host(hwe, hf, ht, hwd);
          host_access(hwe, hf, ht, hwd);
        end
        1: begin
          for (int i = 0; i < k; i++) exp_eng(eng_from_a[i], eng_to_a[i], 1'b0);
          eng_burst(k, cyc);
        end
        default: begin
          plan_both(k, hwe, hf, ht, hwd);
          fork
            host_access(hwe, hf, ht, hwd);
            eng_burst(k, cyc);
          join
        end
      endcase
    end

    idle(3);
    chk("done_queue_drained", exp_done_q.size(), 0);
    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
